ps2_kbd_ctrl: RTL and testbench

- Sequences the PS/2 receive path: consumes the byte stream from the PS/2 receiver (rx_done_tick + 8-bit data) and turns scan-code set 2 sequences into key events.
- Decodes prefixes: E0 = extended, F0 = break, E1 = pause sequence.
- Runs a watchdog that flushes a stuck receiver or a half-parsed sequence.
- Buffers decoded events in a small FIFO with a valid/ready output for downstream consumers (LED/display/UI logic).

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_kbd_ctrl_fifo.sv | 52 +++++
 rtl/ps2_kbd_ctrl.sv | 136 +++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller: parser states, scan-code
// set 2 byte constants and the packed key-event layout.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam int CODE_W = 8;
    localparam int EV_W   = CODE_W + 2;

    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } ps2_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

    function automatic logic is_dev_resp(input logic [7:0] b);
        return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and latches the sticky overflow flag.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code set 2 sequencer: parses prefix bytes into key events,
// guards the receive path with a watchdog and buffers events for consumers.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_busy,
    output logic       rx_flush,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_brk,
    output logic       ev_ext,
    output logic       overflow,
    output logic       timeout_tick,
    output logic [7:0] err_cnt
);
    localparam int WD_W = 20;

    ps2_state_t      state;
    logic [2:0]      skip;
    logic [WD_W-1:0] wd_cnt;
    logic            tick;
    logic            wd_fire;
    logic            push;
    ps2_event_t      push_ev;
    logic            proto_err;
    logic [EV_W-1:0] head;

    // Bytes arriving while the receiver is being flushed are stale.
    assign tick    = rx_done_tick & ~rx_flush;
    assign wd_fire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) & ~tick;

    always_comb begin
        push      = 1'b0;
        push_ev   = '0;
        proto_err = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!is_prefix(rx_data) && !is_dev_resp(rx_data)) begin
                        push    = 1'b1;
                        push_ev = {1'b0, 1'b0, rx_data};
                    end
                end
                ST_E0: begin
                    if (rx_data != PS2_BRK && rx_data != PS2_EXT) begin
                        push    = 1'b1;
                        push_ev = {1'b1, 1'b0, rx_data};
                    end
                end
                ST_F0, ST_E0F0: begin
                    if (is_prefix(rx_data)) begin
                        proto_err = 1'b1;
                    end else begin
                        push    = 1'b1;
                        push_ev = {(state == ST_E0F0), 1'b1, rx_data};
                    end
                end
                ST_PAUSE: begin
                    if (skip == 3'd1) begin
                        push    = 1'b1;
                        push_ev = {1'b1, 1'b0, PS2_PAUSE};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            skip         <= '0;
            wd_cnt       <= '0;
            rx_flush     <= 1'b0;
            timeout_tick <= 1'b0;
            err_cnt      <= '0;
        end else begin
            rx_flush     <= wd_fire;
            timeout_tick <= wd_fire;
            if ((proto_err || wd_fire) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            if (wd_fire) begin
                state  <= ST_IDLE;
                wd_cnt <= '0;
            end else begin
                if (tick || (state == ST_IDLE && !rx_busy)) wd_cnt <= '0;
                else                                        wd_cnt <= wd_cnt + 1'b1;
                if (tick) begin
                    case (state)
                        ST_IDLE: begin
                            if (rx_data == PS2_EXT) state <= ST_E0;
                            else if (rx_data == PS2_BRK) state <= ST_F0;
                            else if (rx_data == PS2_PAUSE) begin
                                state <= ST_PAUSE;
                                skip  <= 3'd7;
                            end
                        end
                        ST_E0: begin
                            if (rx_data == PS2_BRK) state <= ST_E0F0;
                            else if (rx_data != PS2_EXT) state <= ST_IDLE;
                        end
                        ST_PAUSE: begin
                            skip <= skip - 1'b1;
                            if (skip == 3'd1) state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .head      (head),
        .valid     (ev_valid),
        .overflow  (overflow)
    );

    assign {ev_ext, ev_brk, ev_code} = head;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: directed byte streams push expected events,
// a negedge monitor pops and compares every accepted head event.
module tb_ps2_kbd_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic       rx_flush;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_brk;
    logic       ev_ext;
    logic       overflow;
    logic       timeout_tick;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(
        .TIMEOUT_CYCLES (50),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_busy      (rx_busy),
        .rx_flush     (rx_flush),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_code      (ev_code),
        .ev_brk       (ev_brk),
        .ev_ext       (ev_ext),
        .overflow     (overflow),
        .timeout_tick (timeout_tick),
        .err_cnt      (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=%0h expected=none", {ev_ext, ev_brk, ev_code});
            end else begin
                check("event", {22'd0, ev_ext, ev_brk, ev_code}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // expect(ext, brk, code)
    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back({ext, brk, code});
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic drain(input string name);
        repeat (10) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        rx_done_tick = 1'b0;
        rx_busy      = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int pulses;
        rx_data  = 8'h00;
        ev_ready = 1'b1;
        apply_reset();

        check("reset_ev_valid", ev_valid, 0);
        check("reset_ev_fields", {ev_ext, ev_brk, ev_code}, 0);
        check("reset_flush_tick", {rx_flush, timeout_tick}, 0);
        check("reset_overflow", overflow, 0);
        check("reset_err_cnt", err_cnt, 0);

        // Make 1C with first-word-fall-through latency, then break F0 1C.
        expect_ev(1'b0, 1'b0, 8'h1C);
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        rx_data      = 8'h1C;
        @(negedge clk);
        check("latency_before", ev_valid, 0);
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        check("latency_after", ev_valid, 1);
        expect_ev(1'b0, 1'b1, 8'h1C);
        send_seq('{8'hF0, 8'h1C});
        drain("drain_basic");

        // Extended make/break with a device ACK in the middle.
        expect_ev(1'b1, 1'b0, 8'h75);
        expect_ev(1'b1, 1'b1, 8'h75);
        send_seq('{8'hE0, 8'h75, 8'hFA, 8'hE0, 8'hF0, 8'h75});
        drain("drain_ext");

        // Pause sequence yields a single event.
        expect_ev(1'b1, 1'b0, 8'hE1);
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        drain("drain_pause");
        check("pause_err_cnt", err_cnt, 0);

        // Fill the FIFO, drop the fifth event.
        ev_ready = 1'b0;
        expect_ev(1'b0, 1'b0, 8'h15);
        expect_ev(1'b0, 1'b0, 8'h16);
        expect_ev(1'b0, 1'b0, 8'h1E);
        expect_ev(1'b0, 1'b0, 8'h26);
        send_seq('{8'h15, 8'h16, 8'h1E, 8'h26});
        check("full_no_overflow", overflow, 0);
        send_byte(8'h25);
        check("overflow_set", overflow, 1);
        check("full_head_code", ev_code, 8'h15);
        ev_ready = 1'b1;
        drain("drain_overflow");
        check("empty_after_drain", ev_valid, 0);
        check("overflow_sticky", overflow, 1);

        // Double break prefix is a protocol error; reset mid-sequence clears all.
        apply_reset();
        ev_ready = 1'b0;
        send_seq('{8'hF0, 8'hF0});
        check("f0f0_err_cnt", err_cnt, 1);
        check("f0f0_no_event", ev_valid, 0);
        send_seq('{8'h1C, 8'h1D, 8'hE0});
        check("prefill_valid", ev_valid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ev_valid", ev_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset    = 1'b0;
        ev_ready = 1'b1;
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        drain("drain_after_reset");

        // Watchdog on a stalled break prefix.
        apply_reset();
        send_byte(8'hF0);
        n = 0;
        while (!timeout_tick && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_latency", n, 50);
        check("timeout_flush", rx_flush, 1);
        check("timeout_err_cnt", err_cnt, 1);
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (timeout_tick) pulses++;
        end
        check("timeout_single", pulses, 0);
        expect_ev(1'b0, 1'b0, 8'h1C);
        send_byte(8'h1C);
        drain("drain_after_timeout");

        // Receiver stuck busy while the parser is idle.
        rx_busy = 1'b1;
        pulses  = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (timeout_tick) pulses++;
        end
        rx_busy = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (timeout_tick) pulses++;
        end
        check("busy_timeout_pulses", pulses, 1);
        check("busy_err_cnt", err_cnt, 2);
        check("busy_no_event", ev_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
